// File: rtl/mask_bbox_tracker.sv
// mask_bbox_tracker: per-frame object pixel count and bounding box from a binary mask; BBOX_OVERLAY_EN draws the committed box on overlay_out
module mask_bbox_tracker #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        vsync,
  input  logic        de,
  input  logic [15:0] mask_in,
  output logic [9:0]  x_min,
  output logic [9:0]  x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max,
  output logic [18:0] pix_cnt,
  output logic        obj_valid,
  output logic        frame_done,
  output logic [15:0] overlay_out
);
  typedef enum logic [1:0] {WAIT_VS, ACTIVE, COMMIT} state_t;
  localparam logic [9:0] X_LAST = 10'(H_ACT - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACT - 1);
  state_t state, state_nx;
  logic vs_d, de_d, vs_rise, pix, line_end, hit, keep;
  logic [9:0] x, y, acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [18:0] acc_cnt;
  logic [15:0] overlay_nx;
  always_comb begin
    vs_rise = vsync & ~vs_d;
    pix = de & ~vsync;
    line_end = ~de & de_d & ~vsync;
    hit = pix && mask_in == 16'hFFFF;
    keep = acc_cnt >= 19'(MIN_PIXELS);
    state_nx = state == COMMIT ? ACTIVE : !vs_rise ? state : state == WAIT_VS ? ACTIVE : COMMIT;
  end
`ifdef BBOX_OVERLAY_EN
  logic on_box;
  always_comb begin
    on_box = obj_valid && (((x == x_min || x == x_max) && y >= y_min && y <= y_max) ||
                           ((y == y_min || y == y_max) && x >= x_min && x <= x_max));
    overlay_nx = !de ? 16'h0 : on_box ? 16'hF800 : mask_in;
  end
`else
  always_comb overlay_nx = de ? mask_in : 16'h0;
`endif
  // accumulators sit at their clear values whenever not accumulating
  always_ff @(posedge clk)
    if (sys_rst || state != ACTIVE) begin
      x <= '0;
      y <= '0;
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt <= '0;
    end else begin
      if (pix) x <= x == X_LAST ? x : x + 10'd1;
      if (line_end) begin
        x <= '0;
        y <= y == Y_LAST ? y : y + 10'd1;
      end
      if (hit) begin
        acc_cnt <= acc_cnt + 19'(acc_cnt != '1);
        acc_xmin <= x < acc_xmin ? x : acc_xmin;
        acc_xmax <= x > acc_xmax ? x : acc_xmax;
        acc_ymin <= y < acc_ymin ? y : acc_ymin;
        acc_ymax <= y > acc_ymax ? y : acc_ymax;
      end
    end
  always_ff @(posedge clk)
    if (sys_rst) begin
      state <= WAIT_VS;
      vs_d <= 1'b0;
      de_d <= 1'b0;
      x_min <= '0;
      x_max <= '0;
      y_min <= '0;
      y_max <= '0;
      pix_cnt <= '0;
      obj_valid <= 1'b0;
      frame_done <= 1'b0;
      overlay_out <= '0;
    end else begin
      state <= state_nx;
      vs_d <= vsync;
      de_d <= de;
      frame_done <= state == COMMIT;
      overlay_out <= overlay_nx;
      if (state == COMMIT) begin
        x_min <= keep ? acc_xmin : '0;
        x_max <= keep ? acc_xmax : '0;
        y_min <= keep ? acc_ymin : '0;
        y_max <= keep ? acc_ymax : '0;
        pix_cnt <= acc_cnt;
        obj_valid <= keep;
      end
    end
endmodule

// File: doc/mask_bbox_tracker.md
# mask_bbox_tracker

Consumes the binary pixel mask from the HSV colour-threshold stage (16'hFFFF = object, 16'h0000 = background) in raster order. Counts object pixels, tracks the object's bounding box per frame, and publishes the result once per frame at vsync. Sits between the threshold stage and the display/overlay path. Optionally draws the previous frame's box onto the outgoing mask stream.

## Interface
- H_ACT, 640: active pixels per line; x saturates at H_ACT-1
- V_ACT, 480: active lines per frame; y saturates at V_ACT-1
- MIN_PIXELS, 16: minimum object pixel count for a frame result to be valid
- clk  in  1  pixel clock; all logic on the rising edge
- sys_rst  in  1  synchronous, active-high reset
- vsync  in  1  active-high frame sync; its rising edge ends the current frame
- de  in  1  active-video qualifier; one pixel per cycle while high
- mask_in  in  16  mask pixel; a pixel is an object pixel only when mask_in == 16'hFFFF
- x_min, x_max  out  10  bounding box columns of the last committed frame
- y_min, y_max  out  10  bounding box rows of the last committed frame
- pix_cnt  out  19  object pixel count of the last committed frame
- obj_valid  out  1  last committed frame had pix_cnt >= MIN_PIXELS
- frame_done  out  1  one-cycle pulse when results are committed
- overlay_out  out  16  mask stream delayed one cycle (see Configuration)

## Operation
- The block registers vsync and de each cycle as vs_d and de_d.
  - vsync rising edge: vsync=1 and vs_d=0.
  - de falling edge: de=0 and de_d=1.
- States:
  - WAIT_VS: entered on reset. Ignores pixels. Moves to ACTIVE on a vsync rising edge and clears the accumulators.
  - ACTIVE: accumulates pixels. Moves to COMMIT on a vsync rising edge.
  - COMMIT: lasts one cycle. Publishes results, clears the accumulators, returns to ACTIVE.
- Accumulator clear values: acc_xmin = acc_ymin = 10'h3FF, acc_xmax = acc_ymax = 0, acc_cnt = 0, x = 0, y = 0.
- In ACTIVE, each cycle with de=1 and vsync=0:
  - If mask_in == 16'hFFFF:
    - acc_cnt increments, saturating at 2^19-1.
    - acc_xmin = min(acc_xmin, x) and acc_xmax = max(acc_xmax, x).
    - acc_ymin and acc_ymax update the same way with y.
  - x increments, saturating at H_ACT-1.
- On a de falling edge: x returns to 0 and y increments, saturating at V_ACT-1.
- Pixels with de=1 while vsync=1 are ignored and do not move x or y.
- COMMIT with acc_cnt >= MIN_PIXELS:
  - Box outputs take the accumulator values.
  - pix_cnt takes acc_cnt.
  - obj_valid goes to 1.
- COMMIT with acc_cnt < MIN_PIXELS:
  - The four box outputs go to 0.
  - pix_cnt still takes acc_cnt.
  - obj_valid goes to 0.
- Outputs hold between commits.
- Reset asserted mid-frame discards the accumulators. Outputs stay 0 until the first full frame after reset (two vsync edges).

## Timing
- Reset values: every output is 0, state is WAIT_VS, accumulators hold their clear values.
- Commit latency:
  - Let edge N be the clock edge that samples the vsync rising edge.
  - At edge N+1: results update and frame_done=1.
  - At edge N+2: frame_done=0.
- Accumulation starts with the pixels sampled at edge N+2.
- A vsync that stays high for many cycles produces exactly one commit.
- Pixel path: the box and count include the pixel sampled at the same edge. No pixel is lost at line boundaries.
- overlay_out is mask_in registered once (latency 1). It is 0 while de_d=0.

## Configuration
- BBOX_OVERLAY_EN defined:
  - Applies only when obj_valid=1.
  - overlay_out = 16'hF800 (red) when the delayed pixel lies on the perimeter of the committed box: x in {x_min, x_max} with y_min<=y<=y_max, or y in {y_min, y_max} with x_min<=x<=x_max.
  - Otherwise overlay_out is the delayed mask.
- BBOX_OVERLAY_EN undefined: overlay_out is always the delayed mask. No comparators are synthesised. The port still exists.

## Test plan
- Reset, then two frames of all-zero mask (H_ACT=8, V_ACT=4) -> frame_done pulses once per frame; box outputs 0, pix_cnt=0, obj_valid=0.
- Frame with a 4x3 block of 16'hFFFF at x=2..5, y=1..3 and MIN_PIXELS=4 -> x_min=2, x_max=5, y_min=1, y_max=3, pix_cnt=12, obj_valid=1, updated exactly 1 cycle after the vsync edge is sampled.
- Frame with 3 object pixels and MIN_PIXELS=4 -> pix_cnt=3, obj_valid=0, box outputs 0; the next frame's results are independent of the previous one.
- mask_in=16'h7FFF across a whole frame -> pix_cnt=0 (only the exact 16'hFFFF value counts).
- vsync held high 10 cycles, with de pulses during it -> single frame_done; those pixels are not counted and x/y do not advance.
- sys_rst asserted mid-frame, then one full frame containing a pixel at (7,3) -> no commit at the first vsync; after the second vsync x_min=x_max=7 and y_min=y_max=3. With BBOX_OVERLAY_EN defined, overlay_out=16'hF800 at (7,3) on the following frame.
